fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter width, default 32: data word width, matching the FIFO write port.
REQ-002 The block SHALL have parameter depth, default 1024: FIFO depth, used only for documentation of throttle margin.
REQ-003 The block SHALL have parameter max_burst, default 16: maximum words per grant, legal range 2..256.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, the FIFO write clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, 4 bits: per-requester valid, where bit i means requester i presents a word.
REQ-007 The block SHALL have port req_data, input, 4*width bits: requester i data in slice [i*width +: width].
REQ-008 The block SHALL have port full, input, 1 bit: FIFO full flag, write domain.
REQ-009 The block SHALL have port alm_full, input, 1 bit: FIFO almost-full flag, write domain.
REQ-010 The block SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-011 The block SHALL have port ack, output, 4 bits: word of requester i accepted this cycle.
REQ-012 The block SHALL have port wdata, output, width bits: drives FIFO wdata.
REQ-013 The block SHALL have port wrt_enable, output, 1 bit: drives FIFO wrt_enable.
REQ-014 The block SHALL have port burst_cnt, output, 8 bits: words accepted in the current grant.
REQ-015 The block SHALL have port word_cnt, output, 16 bits: total words accepted, wrapping modulo 2^16.

Function
REQ-016 The FSM SHALL have two states: IDLE and BURST.
REQ-017 gnt SHALL be non-zero only in BURST, and SHALL be exactly one-hot there.
REQ-018 In IDLE, when req!=0 and alm_full=0, the next state SHALL be BURST, with gnt set to the first requester with req set, searching round-robin from rr_ptr+1 mod 4.
REQ-019 On that transition, rr_ptr SHALL load the granted index and burst_cnt SHALL clear to 0.
REQ-020 In IDLE, when alm_full=1, no grant SHALL be issued regardless of req.
REQ-021 wrt_enable SHALL equal (state==BURST) & req[g] & ~full, where g is the granted index; it SHALL be combinational from registered state.
REQ-022 ack[g] SHALL equal wrt_enable; all other ack bits SHALL be 0.
REQ-023 A word SHALL be transferred on a clk rising edge where ack[i]=1.
REQ-024 A requester SHALL hold req_data stable while req is high and ack is low.
REQ-025 wdata SHALL equal the req_data slice of g in BURST, and 0 in IDLE.
REQ-026 Each accepted word SHALL increment burst_cnt and word_cnt by 1.
REQ-027 When full=1 in BURST, the block SHALL write nothing, freeze both counters, and hold gnt.
REQ-028 BURST SHALL return to IDLE at the clock edge where any of the following holds: (a) req[g]=0; (b) a word is accepted with burst_cnt==max_burst-1; (c) alm_full=1.
REQ-029 When several exit conditions of REQ-028 coincide, there SHALL be a single transition to IDLE; a word accepted in that cycle SHALL still be counted.
REQ-030 Every grant SHALL be followed by at least one IDLE cycle, so that the grant turnaround is one cycle.
REQ-031 A requester dropping req while ungranted SHALL lose nothing; requests SHALL not be latched.
REQ-032 With all four requesting continuously, the grant order SHALL be 0,1,2,3,0,...; no requester SHALL wait more than 3 bursts.

Reset
REQ-033 When reset=0, the block SHALL immediately and asynchronously force state=IDLE, gnt=0, burst_cnt=0, word_cnt=0 and rr_ptr=3, so that requester 0 wins the first arbitration.
REQ-034 During reset, wrt_enable, ack and wdata SHALL be 0, because they are combinational from IDLE.
REQ-035 Reset asserted mid-burst SHALL abort the burst with no further write; the word presented in that cycle SHALL not be acked.
REQ-036 Reset deassertion SHALL be synchronous to clk; the integrator SHALL drive reset through the existing two-flop reset synchronizer.

Verification
REQ-037 After reset release, drive req=0001 held for 20 words with full=0 and alm_full=0 -> gnt=0001 one cycle later, then 16 acks, 1 IDLE cycle, regrant, 4 acks, then IDLE; word_cnt=20.
REQ-038 Drive req=1111 held with max_burst=16 -> gnt sequence 0001,0010,0100,1000,0001, each 16 acks separated by 1 IDLE cycle.
REQ-039 Drive full=1 for 3 cycles at burst_cnt=5 -> wrt_enable=0 for those 3 cycles, gnt held, burst_cnt stays 5, and burst resumes at 6.
REQ-040 Raise alm_full at burst_cnt=7 with req=0011 -> IDLE next cycle, no grant while alm_full=1, and requester 1 is granted 1 cycle after alm_full falls.
REQ-041 Pull reset low mid-burst (gnt=0100) while req=0100 -> gnt=0 and wrt_enable=0 in the same cycle; after release with req=0101, requester 0 is granted first.
REQ-042 Drop req[g] at the same edge as full=1 and alm_full=1 -> a single transition to IDLE, counters unchanged, and no spurious ack.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Four-way round-robin burst arbiter feeding one FIFO write port.
// Ports: clk, reset (async low); req/req_data in; full/alm_full in;
//   gnt (one-hot, registered), ack, wdata, wrt_enable, burst_cnt,
//   word_cnt out.
module fifo_wr_arbiter #(
  parameter int width     = 32,
  parameter int depth     = 1024,
  parameter int max_burst = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*width-1:0] req_data,
  input  logic               full,
  input  logic               alm_full,
  output logic [3:0]         gnt,
  output logic [3:0]         ack,
  output logic [width-1:0]   wdata,
  output logic               wrt_enable,
  output logic [7:0]         burst_cnt,
  output logic [15:0]        word_cnt
);

  // depth only bounds how much alm_full slack a burst may consume
  if (max_burst < 2 || max_burst > 256 || depth < max_burst)
  begin : g_bad_cfg
    $error("fifo_wr_arbiter: illegal parameters");
  end

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam logic [7:0] LAST = 8'(max_burst - 1);

  state_t      r_state;
  logic [3:0]  r_gnt;
  // last granted index; doubles as the granted index g in BURST
  logic [1:0]  r_rr_ptr;
  logic [7:0]  r_burst_cnt;
  logic [15:0] r_word_cnt;

  logic        w_busy;
  logic        w_we;
  logic        w_last;
  logic        w_exit;
  logic        w_any;
  logic [1:0]  w_pick;
  logic [1:0]  w_idx;

  assign w_busy = (r_state == BURST);
  assign w_we   = w_busy & req[r_rr_ptr] & ~full;
  assign w_last = w_we & (r_burst_cnt == LAST);
  assign w_exit = ~req[r_rr_ptr] | w_last | alm_full;

  // search starts one past the last winner; i=4 wraps to it
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr_ptr + 2'd1;
    w_idx  = r_rr_ptr;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_rr_ptr + 2'(i);
      if (!w_any && req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_gnt       <= 4'b0000;
      r_rr_ptr    <= 2'd3;
      r_burst_cnt <= 8'd0;
      r_word_cnt  <= 16'd0;
    end else begin
      if (w_we) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
        r_word_cnt  <= r_word_cnt + 16'd1;
      end
      unique case (r_state)
        IDLE: begin
          if (w_any && !alm_full) begin
            r_state     <= BURST;
            r_gnt       <= 4'b0001 << w_pick;
            r_rr_ptr    <= w_pick;
            r_burst_cnt <= 8'd0;
          end
        end
        BURST: begin
          // full alone only stalls; any exit cause wins
          if (w_exit) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
          end
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign wrt_enable = w_we;
  assign ack        = w_we ? (4'b0001 << r_rr_ptr) : 4'b0000;
  assign wdata      = w_busy ? req_data[r_rr_ptr*width +: width]
                             : '0;
  assign burst_cnt  = r_burst_cnt;
  assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed checks for fifo_wr_arbiter.
// One task per scenario, inline comparisons.
module tb_fifo_wr_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [4*W-1:0] req_data;
  logic         full;
  logic         alm_full;
  logic [3:0]   gnt;
  logic [3:0]   ack;
  logic [W-1:0] wdata;
  logic         wrt_enable;
  logic [7:0]   burst_cnt;
  logic [15:0]  word_cnt;

  int pass_cnt = 0;
  int total = 0;

  fifo_wr_arbiter #(
    .width(W), .depth(1024), .max_burst(16)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .full(full), .alm_full(alm_full), .gnt(gnt), .ack(ack),
    .wdata(wdata), .wrt_enable(wrt_enable),
    .burst_cnt(burst_cnt), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = 4'b0000;
    req_data = '0;
    full = 1'b0;
    alm_full = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 4'b1111;
    req_data = {4{32'hDEAD_BEEF}};
    full = 1'b0;
    alm_full = 1'b0;
    #3;
    total++;
    if (gnt !== 4'b0000 || ack !== 4'b0000 || wrt_enable !== 1'b0)
      $display("FAIL rst_ctl: gnt=%b ack=%b we=%b want 0", gnt, ack, wrt_enable);
    else pass_cnt++;
    total++;
    if (wdata !== 32'h0 || burst_cnt !== 8'd0 || word_cnt !== 16'd0)
      $display("FAIL rst_data: wdata=%h bc=%0d wc=%0d want 0", wdata, burst_cnt, word_cnt);
    else pass_cnt++;
    tick();
    total++;
    if (gnt !== 4'b0000)
      $display("FAIL rst_hold: gnt=%b want 0000", gnt);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int w;
    int n;
    w = 0;
    do_reset();
    req = 4'b0001;
    req_data[31:0] = 32'hA000_0000;
    tick();
    for (int b = 0; b < 2; b++) begin
      n = (b == 0) ? 16 : 4;
      for (int i = 0; i < n; i++) begin
        req_data[31:0] = 32'hA000_0000 + 32'(w);
        #1;
        total++;
        if (gnt !== 4'b0001 || ack !== 4'b0001 || wrt_enable !== 1'b1)
          $display("FAIL single_ack w%0d: gnt=%b ack=%b we=%b want 0001/0001/1", w, gnt, ack, wrt_enable);
        else pass_cnt++;
        total++;
        if (wdata !== 32'hA000_0000 + 32'(w) || burst_cnt !== 8'(i))
          $display("FAIL single_data w%0d: wdata=%h bc=%0d want %h/%0d", w, wdata, burst_cnt, 32'hA000_0000 + 32'(w), i);
        else pass_cnt++;
        tick();
        w++;
      end
      if (b == 0) begin
        total++;
        if (gnt !== 4'b0000 || wrt_enable !== 1'b0 || word_cnt !== 16'd16)
          $display("FAIL single_idle: gnt=%b we=%b wc=%0d want 0000/0/16", gnt, wrt_enable, word_cnt);
        else pass_cnt++;
        tick();
      end
    end
    req = 4'b0000;
    #1;
    total++;
    if (gnt !== 4'b0001 || ack !== 4'b0000 || word_cnt !== 16'd20 || burst_cnt !== 8'd4)
      $display("FAIL single_drop: gnt=%b ack=%b wc=%0d bc=%0d want 0001/0000/20/4", gnt, ack, word_cnt, burst_cnt);
    else pass_cnt++;
    tick();
    total++;
    if (gnt !== 4'b0000 || word_cnt !== 16'd20)
      $display("FAIL single_end: gnt=%b wc=%0d want 0000/20", gnt, word_cnt);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int r = 0; r < 4; r++)
      req_data[r*W +: W] = 32'hC0DE_0000 + 32'(r);
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      for (int i = 0; i < 16; i++) begin
        total++;
        if (gnt !== (4'b0001 << g) || ack !== (4'b0001 << g) || wdata !== 32'hC0DE_0000 + 32'(g))
          $display("FAIL rr_burst%0d_w%0d: gnt=%b ack=%b wdata=%h want g=%0d", k, i, gnt, ack, wdata, g);
        else pass_cnt++;
        tick();
      end
      total++;
      if (gnt !== 4'b0000 || wrt_enable !== 1'b0)
        $display("FAIL rr_idle%0d: gnt=%b we=%b want 0000/0", k, gnt, wrt_enable);
      else pass_cnt++;
      if (k < 4) tick();
    end
    total++;
    if (word_cnt !== 16'd80)
      $display("FAIL rr_count: wc=%0d want 80", word_cnt);
    else pass_cnt++;
    req = 4'b0000;
  endtask

  task automatic test_full_stall();
    do_reset();
    req = 4'b0001;
    req_data[31:0] = 32'h1234_5678;
    tick();
    for (int i = 0; i < 5; i++) tick();
    full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (wrt_enable !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0001 || burst_cnt !== 8'd5)
        $display("FAIL full_stall%0d: we=%b ack=%b gnt=%b bc=%0d want 0/0000/0001/5", c, wrt_enable, ack, gnt, burst_cnt);
      else pass_cnt++;
      tick();
    end
    full = 1'b0;
    #1;
    total++;
    if (wrt_enable !== 1'b1 || burst_cnt !== 8'd5 || word_cnt !== 16'd5)
      $display("FAIL full_resume: we=%b bc=%0d wc=%0d want 1/5/5", wrt_enable, burst_cnt, word_cnt);
    else pass_cnt++;
    tick();
    total++;
    if (burst_cnt !== 8'd6)
      $display("FAIL full_next: bc=%0d want 6", burst_cnt);
    else pass_cnt++;
    req = 4'b0000;
  endtask

  task automatic test_alm_full();
    do_reset();
    req = 4'b0011;
    req_data[0 +: W] = 32'h0000_00AA;
    req_data[W +: W] = 32'h0000_00BB;
    tick();
    for (int i = 0; i < 7; i++) tick();
    alm_full = 1'b1;
    #1;
    total++;
    if (gnt !== 4'b0001 || wrt_enable !== 1'b1 || burst_cnt !== 8'd7)
      $display("FAIL af_last: gnt=%b we=%b bc=%0d want 0001/1/7", gnt, wrt_enable, burst_cnt);
    else pass_cnt++;
    tick();
    total++;
    if (gnt !== 4'b0000 || burst_cnt !== 8'd8 || word_cnt !== 16'd8)
      $display("FAIL af_idle: gnt=%b bc=%0d wc=%0d want 0000/8/8", gnt, burst_cnt, word_cnt);
    else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (gnt !== 4'b0000 || wrt_enable !== 1'b0)
        $display("FAIL af_hold%0d: gnt=%b we=%b want 0000/0", c, gnt, wrt_enable);
      else pass_cnt++;
    end
    alm_full = 1'b0;
    tick();
    total++;
    if (gnt !== 4'b0010 || wdata !== 32'h0000_00BB || burst_cnt !== 8'd0)
      $display("FAIL af_regrant: gnt=%b wdata=%h bc=%0d want 0010/000000bb/0", gnt, wdata, burst_cnt);
    else pass_cnt++;
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    req_data[2*W +: W] = 32'h5555_0002;
    tick();
    total++;
    if (gnt !== 4'b0100)
      $display("FAIL rm_grant: gnt=%b want 0100", gnt);
    else pass_cnt++;
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (gnt !== 4'b0000 || wrt_enable !== 1'b0 || ack !== 4'b0000 || wdata !== 32'h0)
      $display("FAIL rm_abort: gnt=%b we=%b ack=%b wdata=%h want 0", gnt, wrt_enable, ack, wdata);
    else pass_cnt++;
    total++;
    if (burst_cnt !== 8'd0 || word_cnt !== 16'd0)
      $display("FAIL rm_cnt: bc=%0d wc=%0d want 0/0", burst_cnt, word_cnt);
    else pass_cnt++;
    tick();
    reset = 1'b1;
    req = 4'b0101;
    req_data[0 +: W] = 32'h5555_0000;
    tick();
    total++;
    if (gnt !== 4'b0001 || wdata !== 32'h5555_0000)
      $display("FAIL rm_first: gnt=%b wdata=%h want 0001/55550000", gnt, wdata);
    else pass_cnt++;
    req = 4'b0000;
  endtask

  task automatic test_combo_exit();
    do_reset();
    req = 4'b0001;
    req_data[31:0] = 32'h7777_7777;
    tick();
    tick();
    tick();
    req = 4'b0000;
    full = 1'b1;
    alm_full = 1'b1;
    #1;
    total++;
    if (ack !== 4'b0000 || wrt_enable !== 1'b0 || gnt !== 4'b0001)
      $display("FAIL combo_cycle: ack=%b we=%b gnt=%b want 0000/0/0001", ack, wrt_enable, gnt);
    else pass_cnt++;
    tick();
    total++;
    if (gnt !== 4'b0000 || burst_cnt !== 8'd2 || word_cnt !== 16'd2 || ack !== 4'b0000)
      $display("FAIL combo_idle: gnt=%b bc=%0d wc=%0d ack=%b want 0000/2/2/0000", gnt, burst_cnt, word_cnt, ack);
    else pass_cnt++;
    tick();
    total++;
    if (gnt !== 4'b0000 || word_cnt !== 16'd2)
      $display("FAIL combo_stay: gnt=%b wc=%0d want 0000/2", gnt, word_cnt);
    else pass_cnt++;
    full = 1'b0;
    alm_full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_alm_full();
    test_reset_mid();
    test_combo_exit();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
